// File: rtl/gf16_sched_pkg.sv
// Shared types and constants for the masked GF(2^4) multiplier scheduler:
// FSM states, LFSR polynomial/default seed and operand share packing offsets.
package gf16_sched_pkg;

    typedef enum logic [1:0] {
        S_SEED,
        S_WARM,
        S_RUN
    } state_t;

    localparam logic [31:0] LFSR_POLY     = 32'h0040_0007;
    localparam logic [31:0] LFSR_DEF_SEED = 32'h0000_0001;

    localparam int OP_W     = 24;
    localparam int OFF_INH0 = 20;
    localparam int OFF_INH1 = 16;
    localparam int OFF_INL0 = 12;
    localparam int OFF_INL1 = 8;
    localparam int OFF_IN0  = 4;
    localparam int OFF_IN1  = 0;

    // One Galois step: shift left, fold x^32 back through the tap mask.
    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return s[31] ? ({s[30:0], 1'b0} ^ LFSR_POLY) : {s[30:0], 1'b0};
    endfunction

endpackage

// File: rtl/gf16_sched_lfsr.sv
// 32-bit Galois LFSR advancing 8 steps per cycle, with seed load and
// zero-seed substitution; exposes the low byte as fresh mask randomness.
module gf16_sched_lfsr
    import gf16_sched_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        adv,
    input  logic [31:0] seed,
    output logic [7:0]  rnd
);

    logic [31:0] state;

    function automatic logic [31:0] step8(input logic [31:0] s);
        logic [31:0] t;
        t = s;
        for (int i = 0; i < 8; i++) begin
            t = lfsr_step(t);
        end
        return t;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= LFSR_DEF_SEED;
        end else if (load) begin
            // An all-zero state would lock the LFSR, so substitute the default.
            state <= (seed == 32'h0) ? LFSR_DEF_SEED : seed;
        end else if (adv) begin
            state <= step8(state);
        end
    end

    assign rnd = state[7:0];

endmodule

// File: rtl/gf16_mul_sched.sv
// Round-robin scheduler sharing one 2-share masked GF(2^4) multiplier among
// N_REQ requesters. Optional macro GF16_SCHED_ZEROIZE_EN zeroes idle operands.
module gf16_mul_sched
    import gf16_sched_pkg::*;
#(
    parameter int N_REQ    = 4,
    parameter int MUL_LAT  = 1,
    parameter int WARM_CYC = 16,
    parameter int ID_W     = 2
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  seed_valid,
    input  logic [31:0]           seed,
    input  logic [N_REQ-1:0]      req,
    input  logic [N_REQ*OP_W-1:0] req_data,
    output logic [N_REQ-1:0]      gnt,
    output logic [OP_W-1:0]       mul_op,
    output logic [7:0]            mul_r,
    input  logic [15:0]           mul_res,
    output logic                  res_valid,
    output logic [ID_W-1:0]       res_id,
    output logic [15:0]           res_data,
    output logic                  busy
);

    localparam int CNT_W = (WARM_CYC > 1) ? $clog2(WARM_CYC) : 1;

    state_t            state;
    logic [CNT_W-1:0]  warm_cnt;
    logic [ID_W-1:0]   ptr;
    logic [ID_W-1:0]   ptr_next;
    logic              gnt_any;
    logic [ID_W-1:0]   gnt_idx;
    logic [7:0]        rnd;
    logic [MUL_LAT-1:0] tag_vld;
    logic [ID_W-1:0]   tag_id [MUL_LAT];

    gf16_sched_lfsr u_lfsr (
        .clk  (CLK),
        .rst  (RST),
        .load (seed_valid),
        .adv  ((state == S_WARM) || (state == S_RUN)),
        .seed (seed),
        .rnd  (rnd)
    );

    // Round-robin search starting at ptr, wrapping at N_REQ-1.
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        gnt     = '0;
        if (state == S_RUN) begin
            for (int k = 0; k < N_REQ; k++) begin
                if (!gnt_any && req[(int'(ptr) + k) % N_REQ]) begin
                    gnt_any = 1'b1;
                    gnt_idx = ID_W'((int'(ptr) + k) % N_REQ);
                end
            end
        end
        if (gnt_any) begin
            gnt[gnt_idx] = 1'b1;
        end
    end

    assign ptr_next = (gnt_idx == ID_W'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state    <= S_SEED;
            warm_cnt <= '0;
            ptr      <= '0;
        end else begin
            if (gnt_any) begin
                ptr <= ptr_next;
            end
            if (seed_valid) begin
                state    <= S_WARM;
                warm_cnt <= '0;
            end else begin
                case (state)
                    S_WARM: begin
                        if (warm_cnt == CNT_W'(WARM_CYC - 1)) begin
                            state <= S_RUN;
                        end else begin
                            warm_cnt <= warm_cnt + 1'b1;
                        end
                    end
                    S_SEED, S_RUN: ;
                    default: state <= S_SEED;
                endcase
            end
        end
    end

    // Tag pipeline runs independently of the FSM so in-flight ops drain across a reseed.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            tag_vld <= '0;
            for (int i = 0; i < MUL_LAT; i++) begin
                tag_id[i] <= '0;
            end
        end else begin
            tag_vld[0] <= gnt_any;
            tag_id[0]  <= gnt_idx;
            for (int i = 1; i < MUL_LAT; i++) begin
                tag_vld[i] <= tag_vld[i-1];
                tag_id[i]  <= tag_id[i-1];
            end
        end
    end

`ifdef GF16_SCHED_ZEROIZE_EN
    assign mul_op = gnt_any ? req_data[int'(gnt_idx)*OP_W +: OP_W] : '0;
    assign mul_r  = gnt_any ? rnd : 8'h00;
`else
    logic [ID_W-1:0] sel_q;
    logic            sel_vld;
    logic [7:0]      r_hold;

    // Idle cycles replay the last selection so the datapath inputs stay still.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sel_q   <= '0;
            sel_vld <= 1'b0;
            r_hold  <= 8'h00;
        end else if (gnt_any) begin
            sel_q   <= gnt_idx;
            sel_vld <= 1'b1;
            r_hold  <= rnd;
        end
    end

    assign mul_op = gnt_any ? req_data[int'(gnt_idx)*OP_W +: OP_W] :
                    sel_vld ? req_data[int'(sel_q)*OP_W +: OP_W]   : '0;
    assign mul_r  = gnt_any ? rnd : r_hold;
`endif

    assign res_valid = tag_vld[MUL_LAT-1];
    assign res_id    = tag_id[MUL_LAT-1];
    assign res_data  = mul_res;
    assign busy      = (state != S_RUN) || (|tag_vld);

endmodule

// File: tb/tb_gf16_mul_sched.sv
// Self-checking bench for gf16_mul_sched: reference LFSR/arbiter model plus a
// result scoreboard keyed by requester ID and due cycle.
module tb_gf16_mul_sched;

    localparam int N_REQ    = 4;
    localparam int MUL_LAT  = 1;
    localparam int WARM_CYC = 16;
    localparam int ID_W     = 2;

    logic                CLK = 1'b0;
    logic                RST = 1'b1;
    logic                seed_valid = 1'b0;
    logic [31:0]         seed = 32'h0;
    logic [N_REQ-1:0]    req = '0;
    logic [N_REQ*24-1:0] req_data = '0;
    logic [N_REQ-1:0]    gnt;
    logic [23:0]         mul_op;
    logic [7:0]          mul_r;
    logic [15:0]         mul_res = 16'h0;
    logic                res_valid;
    logic [ID_W-1:0]     res_id;
    logic [15:0]         res_data;
    logic                busy;

    gf16_mul_sched #(
        .N_REQ(N_REQ), .MUL_LAT(MUL_LAT), .WARM_CYC(WARM_CYC), .ID_W(ID_W)
    ) dut (
        .CLK(CLK), .RST(RST), .seed_valid(seed_valid), .seed(seed),
        .req(req), .req_data(req_data), .gnt(gnt), .mul_op(mul_op),
        .mul_r(mul_r), .mul_res(mul_res), .res_valid(res_valid),
        .res_id(res_id), .res_data(res_data), .busy(busy)
    );

    always #5 CLK = ~CLK;

    typedef struct { int id; int due; } sb_t;
    sb_t sb[$];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Reference model: 0=SEED, 1=WARM, 2=RUN
    int          m_state = 0;
    int          m_cnt   = 0;
    int          m_ptr   = 0;
    logic [31:0] m_lfsr  = 32'h1;

    function automatic logic [31:0] ref_step8(input logic [31:0] s);
        logic [31:0] t;
        t = s;
        for (int i = 0; i < 8; i++) begin
            if (t[31]) t = {t[30:0], 1'b0} ^ 32'h0040_0007;
            else       t = {t[30:0], 1'b0};
        end
        return t;
    endfunction

    function automatic int model_grant();
        if (m_state != 2) return -1;
        for (int k = 0; k < N_REQ; k++) begin
            if (req[(m_ptr + k) % N_REQ]) return (m_ptr + k) % N_REQ;
        end
        return -1;
    endfunction

    function automatic logic [23:0] slice(input int i);
        logic [N_REQ*24-1:0] d;
        d = req_data;
        return d[i*24 +: 24];
    endfunction

    task automatic model_reset();
        m_state = 0; m_cnt = 0; m_ptr = 0; m_lfsr = 32'h1;
        sb.delete();
    endtask

    // Advance model and DUT one clock; pop and compare any result now due.
    task automatic next_cycle();
        int gi;
        sb_t e;
        gi = model_grant();
        if (gi >= 0) begin
            sb.push_back('{id: gi, due: cyc + MUL_LAT});
            m_ptr = (gi + 1) % N_REQ;
        end
        if (seed_valid) begin
            m_lfsr = (seed == 32'h0) ? 32'h1 : seed;
            m_state = 1; m_cnt = 0;
        end else if (m_state == 1) begin
            m_lfsr = ref_step8(m_lfsr);
            if (m_cnt == WARM_CYC - 1) m_state = 2;
            else m_cnt++;
        end else if (m_state == 2) begin
            m_lfsr = ref_step8(m_lfsr);
        end
        @(posedge CLK);
        cyc++;
        @(negedge CLK);
        mul_res = 16'($urandom);
        #1;
        n_checks++;
        if (res_valid === 1'b1) begin
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL res_unexpected: res_valid=1 id=%0d with empty scoreboard", res_id);
            end else begin
                e = sb.pop_front();
                if (e.due != cyc || res_id !== ID_W'(e.id) || res_data !== mul_res) begin
                    n_fail++;
                    $display("FAIL res_match: got id=%0d data=%h cyc=%0d, want id=%0d data=%h cyc=%0d",
                             res_id, res_data, cyc, e.id, mul_res, e.due);
                end
            end
        end else if (sb.size() != 0 && sb[0].due <= cyc) begin
            e = sb.pop_front();
            n_fail++;
            $display("FAIL res_missing: res_valid=%b, want pulse for id=%0d at cyc=%0d", res_valid, e.id, e.due);
        end
    endtask

    task automatic test_reset();
        RST = 1'b1;
        @(negedge CLK); #1;
        n_checks++;
        if (gnt !== 4'b0 || res_valid !== 1'b0 || res_id !== 2'd0 || mul_op !== 24'h0 ||
            mul_r !== 8'h0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_vals: gnt=%b rv=%b id=%0d op=%h r=%h busy=%b, want 0 0 0 0 0 1",
                     gnt, res_valid, res_id, mul_op, mul_r, busy);
        end
        @(negedge CLK); #1;
        RST = 1'b0;
        model_reset();
    endtask

    task automatic test_seed_warm();
        logic [3:0] seq [5];
        seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        seed = 32'hDEADBEEF; seed_valid = 1'b1; req = 4'b1111;
        #1;
        n_checks++;
        if (gnt !== 4'b0) begin
            n_fail++; $display("FAIL seed_nogrant: gnt=%b want 0000", gnt);
        end
        next_cycle();
        seed_valid = 1'b0;
        for (int c = 0; c < WARM_CYC; c++) begin
            #1;
            n_checks++;
            if (gnt !== 4'b0 || busy !== 1'b1) begin
                n_fail++; $display("FAIL warm_c%0d: gnt=%b busy=%b want 0000 1", c, gnt, busy);
            end
            next_cycle();
        end
        for (int c = 0; c < 5; c++) begin
            #1;
            n_checks++;
            if (gnt !== seq[c] || mul_op !== slice(c % N_REQ) || mul_r !== m_lfsr[7:0]) begin
                n_fail++;
                $display("FAIL rr_seq%0d: gnt=%b op=%h r=%h want %b %h %h",
                         c, gnt, mul_op, mul_r, seq[c], slice(c % N_REQ), m_lfsr[7:0]);
            end
            next_cycle();
        end
        req = 4'b0;
        next_cycle();
        next_cycle();
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++; $display("FAIL idle_busy: busy=%b want 0", busy);
        end
    endtask

    task automatic test_zero_seed();
        int zeros = 0;
        seed = 32'h0; seed_valid = 1'b1; req = 4'b0;
        next_cycle();
        seed_valid = 1'b0;
        repeat (WARM_CYC) next_cycle();
        req = 4'b0001;
        for (int c = 0; c < 1000; c++) begin
            #1;
            n_checks++;
            if (gnt !== 4'b0001 || mul_r !== m_lfsr[7:0]) begin
                n_fail++;
                $display("FAIL zseed_r%0d: gnt=%b r=%h want 0001 %h", c, gnt, mul_r, m_lfsr[7:0]);
            end
            if (mul_r == 8'h00) zeros++;
            next_cycle();
        end
        n_checks++;
        if (zeros > 40) begin
            n_fail++; $display("FAIL zseed_stuck: %0d zero bytes in 1000, want <= 40", zeros);
        end
        req = 4'b0;
        next_cycle();
    endtask

    task automatic test_wrap();
        logic [3:0] seq [4];
        int cnt1 = 0;
        int cnt2 = 0;
        seq = '{4'b0100, 4'b0010, 4'b0100, 4'b0010};
        for (int c = 0; c < 8; c++) begin
            req = (c == 0) ? 4'b0100 : 4'b0110;
            #1;
            if (c < 4) begin
                n_checks++;
                if (gnt !== seq[c]) begin
                    n_fail++; $display("FAIL wrap_seq%0d: gnt=%b want %b", c, gnt, seq[c]);
                end
            end
            if (gnt[1]) cnt1++;
            if (gnt[2]) cnt2++;
            next_cycle();
        end
        n_checks++;
        if (cnt1 < 3 || cnt2 < 3) begin
            n_fail++; $display("FAIL wrap_fair: grants r1=%0d r2=%0d want >=3 each", cnt1, cnt2);
        end
        req = 4'b0;
        next_cycle();
    endtask

    task automatic test_reseed_inflight();
        int gi;
        req = 4'b0001;
        #1;
        n_checks++;
        if (gnt !== 4'b0001) begin
            n_fail++; $display("FAIL rs_grant: gnt=%b want 0001", gnt);
        end
        next_cycle();
        req = 4'b0; seed = 32'h1234_5678; seed_valid = 1'b1;
        #1;
        n_checks++;
        if (busy !== 1'b1 || gnt !== 4'b0) begin
            n_fail++; $display("FAIL rs_busy: busy=%b gnt=%b want 1 0000", busy, gnt);
        end
        next_cycle();
        seed_valid = 1'b0; req = 4'b1111;
        for (int c = 0; c < WARM_CYC; c++) begin
            #1;
            n_checks++;
            if (gnt !== 4'b0 || busy !== 1'b1) begin
                n_fail++; $display("FAIL rs_warm%0d: gnt=%b busy=%b want 0000 1", c, gnt, busy);
            end
            next_cycle();
        end
        #1;
        gi = model_grant();
        n_checks++;
        if (gi < 0 || gnt !== (4'b0001 << gi) || mul_r !== m_lfsr[7:0]) begin
            n_fail++; $display("FAIL rs_resume: gnt=%b r=%h want idx %0d r=%h", gnt, mul_r, gi, m_lfsr[7:0]);
        end
        next_cycle();
        req = 4'b0;
        next_cycle();
    endtask

    task automatic test_idle_hold();
        logic [23:0] exp_op;
        logic [7:0]  exp_r;
        req = 4'b0010;
        #1;
        exp_op = slice(1);
        exp_r  = m_lfsr[7:0];
        n_checks++;
        if (gnt !== 4'b0010 || mul_op !== exp_op || mul_r !== exp_r) begin
            n_fail++; $display("FAIL idle_grant: gnt=%b op=%h r=%h want 0010 %h %h", gnt, mul_op, mul_r, exp_op, exp_r);
        end
`ifdef GF16_SCHED_ZEROIZE_EN
        exp_op = 24'h0;
        exp_r  = 8'h0;
`endif
        next_cycle();
        req = 4'b0;
        for (int c = 0; c < 2; c++) begin
            #1;
            n_checks++;
            if (gnt !== 4'b0 || mul_op !== exp_op || mul_r !== exp_r) begin
                n_fail++; $display("FAIL idle_c%0d: gnt=%b op=%h r=%h want 0000 %h %h", c, gnt, mul_op, mul_r, exp_op, exp_r);
            end
            next_cycle();
        end
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++; $display("FAIL sb_drain: %0d results outstanding, want 0", sb.size());
        end
    endtask

    task automatic test_reset_midop();
        req = 4'b0001;
        #1;
        n_checks++;
        if (gnt !== 4'b0001) begin
            n_fail++; $display("FAIL rm_grant: gnt=%b want 0001", gnt);
        end
        #1;
        RST = 1'b1;
        #1;
        n_checks++;
        if (gnt !== 4'b0 || res_valid !== 1'b0 || res_id !== 2'd0 || mul_op !== 24'h0 ||
            mul_r !== 8'h0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL rm_vals: gnt=%b rv=%b id=%0d op=%h r=%h busy=%b, want 0 0 0 0 0 1",
                     gnt, res_valid, res_id, mul_op, mul_r, busy);
        end
        for (int c = 0; c < 3; c++) begin
            @(negedge CLK); #1;
            n_checks++;
            if (res_valid !== 1'b0 || gnt !== 4'b0) begin
                n_fail++; $display("FAIL rm_quiet%0d: rv=%b gnt=%b want 0 0000", c, res_valid, gnt);
            end
        end
        RST = 1'b0;
        req = 4'b0;
        model_reset();
    endtask

    initial begin
        for (int i = 0; i < N_REQ; i++) begin
            req_data[i*24 +: 24] = 24'($urandom);
        end
        test_reset();
        test_seed_warm();
        test_zero_seed();
        test_wrap();
        test_reseed_inflight();
        test_idle_hold();
        test_reset_midop();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
